// File: rtl/jtag_pkg.sv
// Shared TAP controller types: state encoding, opcodes and select bundle.
package jtag_pkg;

  localparam int IR_LEN = 4;

  typedef enum logic [3:0] {
    TLR    = 4'h0,
    RTI    = 4'h1,
    SEL_DR = 4'h2,
    CAP_DR = 4'h3,
    SH_DR  = 4'h4,
    EX1_DR = 4'h5,
    PAU_DR = 4'h6,
    EX2_DR = 4'h7,
    UPD_DR = 4'h8,
    SEL_IR = 4'h9,
    CAP_IR = 4'hA,
    SH_IR  = 4'hB,
    EX1_IR = 4'hC,
    PAU_IR = 4'hD,
    EX2_IR = 4'hE,
    UPD_IR = 4'hF
  } tap_state_e;

  localparam logic [IR_LEN-1:0] OP_EXTEST  = 4'b0000;
  localparam logic [IR_LEN-1:0] OP_SAMPLE  = 4'b0001;
  localparam logic [IR_LEN-1:0] OP_IDCODE  = 4'b0010;
  localparam logic [IR_LEN-1:0] OP_DEBUG   = 4'b1000;
  localparam logic [IR_LEN-1:0] OP_MBIST   = 4'b1001;
  localparam logic [IR_LEN-1:0] OP_BYPASS  = 4'b1111;
  localparam logic [IR_LEN-1:0] CAPTURE_IR = 4'b0101;

  typedef struct packed {
    logic extest;
    logic sample;
    logic idcode;
    logic debug;
    logic mbist;
    logic bypass;
  } sel_t;

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP FSM: state register, next-state logic and state strobes.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       tclk,
  input  logic       rst,
  input  logic       tms,
  output tap_state_e state,
  output tap_state_e next_state,
  output logic       tlr,
  output logic       shift_dr,
  output logic       pause_dr,
  output logic       update_dr,
  output logic       capture_dr
);

  always_ff @(posedge tclk or posedge rst) begin
    if (rst) state <= TLR;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      TLR:    next_state = tms ? TLR    : RTI;
      RTI:    next_state = tms ? SEL_DR : RTI;
      SEL_DR: next_state = tms ? SEL_IR : CAP_DR;
      CAP_DR: next_state = tms ? EX1_DR : SH_DR;
      SH_DR:  next_state = tms ? EX1_DR : SH_DR;
      EX1_DR: next_state = tms ? UPD_DR : PAU_DR;
      PAU_DR: next_state = tms ? EX2_DR : PAU_DR;
      EX2_DR: next_state = tms ? UPD_DR : SH_DR;
      UPD_DR: next_state = tms ? SEL_DR : RTI;
      SEL_IR: next_state = tms ? TLR    : CAP_IR;
      CAP_IR: next_state = tms ? EX1_IR : SH_IR;
      SH_IR:  next_state = tms ? EX1_IR : SH_IR;
      EX1_IR: next_state = tms ? UPD_IR : PAU_IR;
      PAU_IR: next_state = tms ? EX2_IR : PAU_IR;
      EX2_IR: next_state = tms ? UPD_IR : SH_IR;
      UPD_IR: next_state = tms ? SEL_DR : RTI;
      default: next_state = TLR;
    endcase
  end

  assign tlr        = (state == TLR);
  assign shift_dr   = (state == SH_DR);
  assign pause_dr   = (state == PAU_DR);
  assign update_dr  = (state == UPD_DR);
  assign capture_dr = (state == CAP_DR);

endmodule

// File: rtl/jtag_tap_ctrl.sv
// TAP controller top: IR, BYPASS/IDCODE registers, decode and TDO mux.
module jtag_tap_ctrl
  import jtag_pkg::*;
#(
  parameter logic [31:0] IDCODE_VALUE = 32'h1018_0A4B
) (
  input  logic tclk,
  input  logic test_logic_reset_i,
  input  logic tms_i,
  input  logic tdi_i,
  output logic tdo_o,
  output logic tdo_oe_o,
  output logic tdi_o,
  output logic test_logic_reset_o,
  output logic shift_dr_o,
  output logic pause_dr_o,
  output logic update_dr_o,
  output logic capture_dr_o,
  output logic extest_sel_o,
  output logic sample_preload_sel_o,
  output logic idcode_sel_o,
  output logic debug_sel_o,
  output logic mbist_sel_o,
  output logic bypass_sel_o,
  input  logic bs_chain_tdo_i,
  input  logic debug_tdo_i,
  input  logic mbist_tdo_i
);

  tap_state_e        state;
  tap_state_e        next_state;
  logic [IR_LEN-1:0] ir_sr;
  logic [IR_LEN-1:0] ir;
  logic              bypass;
  logic [31:0]       idcode_sr;
  sel_t              sel;
  logic              dr_tdo;

  jtag_tap_fsm u_fsm (
    .tclk       (tclk),
    .rst        (test_logic_reset_i),
    .tms        (tms_i),
    .state      (state),
    .next_state (next_state),
    .tlr        (test_logic_reset_o),
    .shift_dr   (shift_dr_o),
    .pause_dr   (pause_dr_o),
    .update_dr  (update_dr_o),
    .capture_dr (capture_dr_o)
  );

  assign tdi_o = tdi_i;

  always_ff @(posedge tclk or posedge test_logic_reset_i) begin
    if (test_logic_reset_i) begin
      ir_sr <= OP_IDCODE;
      ir    <= OP_IDCODE;
    end else begin
      if (state == CAP_IR)
        ir_sr <= CAPTURE_IR;
      else if (state == SH_IR)
        ir_sr <= {tdi_i, ir_sr[IR_LEN-1:1]};
      // TLR entry via TMS must win so the select is IDCODE on arrival
      if (next_state == TLR)
        ir <= OP_IDCODE;
      else if (state == UPD_IR)
        ir <= ir_sr;
    end
  end

  always_ff @(posedge tclk or posedge test_logic_reset_i) begin
    if (test_logic_reset_i) begin
      bypass    <= 1'b0;
      idcode_sr <= IDCODE_VALUE;
    end else begin
      if (state == CAP_DR)
        bypass <= 1'b0;
      else if (state == SH_DR)
        bypass <= tdi_i;
      if (sel.idcode && state == CAP_DR)
        idcode_sr <= IDCODE_VALUE;
      else if (sel.idcode && state == SH_DR)
        idcode_sr <= {tdi_i, idcode_sr[31:1]};
    end
  end

  always_comb begin
    sel = '0;
    case (ir)
      OP_EXTEST: sel.extest = 1'b1;
      OP_SAMPLE: sel.sample = 1'b1;
      OP_IDCODE: sel.idcode = 1'b1;
      OP_DEBUG:  sel.debug  = 1'b1;
      OP_MBIST:  sel.mbist  = 1'b1;
      default:   sel.bypass = 1'b1;
    endcase
  end

  assign extest_sel_o         = sel.extest;
  assign sample_preload_sel_o = sel.sample;
  assign idcode_sel_o         = sel.idcode;
  assign debug_sel_o          = sel.debug;
  assign mbist_sel_o          = sel.mbist;
  assign bypass_sel_o         = sel.bypass;

  always_comb begin
    dr_tdo = bypass;
    unique case (1'b1)
      sel.extest: dr_tdo = bs_chain_tdo_i;
      sel.sample: dr_tdo = bs_chain_tdo_i;
      sel.idcode: dr_tdo = idcode_sr[0];
      sel.debug:  dr_tdo = debug_tdo_i;
      sel.mbist:  dr_tdo = mbist_tdo_i;
      sel.bypass: dr_tdo = bypass;
      default:    dr_tdo = bypass;
    endcase
  end

  always_ff @(negedge tclk or posedge test_logic_reset_i) begin
    if (test_logic_reset_i) begin
      tdo_o    <= 1'b0;
      tdo_oe_o <= 1'b0;
    end else begin
      tdo_oe_o <= (state == SH_DR) || (state == SH_IR);
      if (state == SH_IR)
        tdo_o <= ir_sr[0];
      else if (state == SH_DR)
        tdo_o <= dr_tdo;
    end
  end

endmodule
